sha256_nonce_scheduler: RTL and testbench

SHA256_NONCE_SCHEDULER -- requirements
Module: sha256_nonce_scheduler

---
 rtl/sha256_nonce_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_sha256_nonce_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_scheduler.sv
// Nonce search sequencer for an external SHA-256 compression core.
// Walks nonce_start..nonce_end (inclusive, wrapping mod 2^32), hashing each
// header tail through the core and stopping on the first hash <= target.
// Optional build macro: DOUBLE_HASH_EN adds the second SHA-256 pass
// (P2_START/P2_WAIT). Without it the pass-1 digest is compared directly.
module sha256_nonce_scheduler #(
    parameter int CORE_LATENCY = 65
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         go,
    input  logic         abort,
    input  logic [255:0] midstate,
    input  logic [95:0]  tail,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [255:0] hash_out,
    output logic [255:0] core_init,
    output logic [511:0] core_value,
    output logic         core_start,
    input  logic [255:0] core_result
);

    localparam int CW = (CORE_LATENCY > 2) ? $clog2(CORE_LATENCY) : 1;
    // Loaded in the start cycle; core_result is captured when the count hits zero,
    // which is exactly CORE_LATENCY cycles after the start cycle.
    localparam logic [CW-1:0] WAIT_LOAD = CW'(CORE_LATENCY - 1);

`ifdef DOUBLE_HASH_EN
    localparam logic [255:0] SHA_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`endif

    typedef enum logic [2:0] {
        IDLE, P1_START, P1_WAIT, P2_START, P2_WAIT, CHECK
    } state_e;

    // Second header block: words 16-18, nonce, pad bit, zero fill and the
    // 64-bit bit length (640) closing out exactly 512 bits.
    function automatic logic [511:0] p1_block(input logic [95:0] t, input logic [31:0] n);
        return {t, n, 32'h80000000, 288'h0, 64'd640};
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    end_q, end_d;
    logic [255:0]   mid_q, mid_d;
    logic [95:0]    tail_q, tail_d;
    logic [255:0]   target_q, target_d;
    logic [255:0]   res_q, res_d;
    logic [255:0]   cinit_q, cinit_d;
    logic [511:0]   cval_q, cval_d;
    logic [31:0]    nout_q, nout_d;
    logic [255:0]   hout_q, hout_d;
    logic           done_q, done_d;
    logic           found_q, found_d;
    logic [31:0]    nonce_inc;

    assign nonce_inc  = nonce_q + 32'd1;
    assign busy       = (state_q != IDLE);
    assign core_start = (state_q == P1_START) || (state_q == P2_START);
    assign done       = done_q;
    assign found      = found_q;
    assign nonce_out  = nout_q;
    assign hash_out   = hout_q;
    assign core_init  = cinit_q;
    assign core_value = cval_q;

    // Next-state and datapath: abort wins in every state, including over go in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nonce_d  = nonce_q;
        end_d    = end_q;
        mid_d    = mid_q;
        tail_d   = tail_q;
        target_d = target_q;
        res_d    = res_q;
        cinit_d  = cinit_q;
        cval_d   = cval_q;
        nout_d   = nout_q;
        hout_d   = hout_q;
        done_d   = 1'b0;
        found_d  = found_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        mid_d    = midstate;
                        tail_d   = tail;
                        target_d = target;
                        end_d    = nonce_end;
                        nonce_d  = nonce_start;
                        cinit_d  = midstate;
                        cval_d   = p1_block(tail, nonce_start);
                        state_d  = P1_START;
                    end
                end
                P1_START: begin
                    cnt_d   = WAIT_LOAD;
                    state_d = P1_WAIT;
                end
                P1_WAIT: begin
                    if (cnt_q == '0) begin
`ifdef DOUBLE_HASH_EN
                        cinit_d = SHA_IV;
                        cval_d  = {core_result, 32'h80000000, 160'h0, 64'd256};
                        state_d = P2_START;
`else
                        res_d   = core_result;
                        state_d = CHECK;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef DOUBLE_HASH_EN
                P2_START: begin
                    cnt_d   = WAIT_LOAD;
                    state_d = P2_WAIT;
                end
                P2_WAIT: begin
                    if (cnt_q == '0) begin
                        res_d   = core_result;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`endif
                CHECK: begin
                    if (res_q <= target_q) begin
                        nout_d  = nonce_q;
                        hout_d  = res_q;
                        done_d  = 1'b1;
                        found_d = 1'b1;
                        state_d = IDLE;
                    end else if (nonce_q == end_q) begin
                        nout_d  = nonce_q;
                        hout_d  = res_q;
                        done_d  = 1'b1;
                        found_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        nonce_d = nonce_inc;
                        cinit_d = mid_q;
                        cval_d  = p1_block(tail_q, nonce_inc);
                        state_d = P1_START;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset clears everything and kills any search.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            nonce_q  <= '0;
            end_q    <= '0;
            mid_q    <= '0;
            tail_q   <= '0;
            target_q <= '0;
            res_q    <= '0;
            cinit_q  <= '0;
            cval_q   <= '0;
            nout_q   <= '0;
            hout_q   <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nonce_q  <= nonce_d;
            end_q    <= end_d;
            mid_q    <= mid_d;
            tail_q   <= tail_d;
            target_q <= target_d;
            res_q    <= res_d;
            cinit_q  <= cinit_d;
            cval_q   <= cval_d;
            nout_q   <= nout_d;
            hout_q   <= hout_d;
            done_q   <= done_d;
            found_q  <= found_d;
        end
    end

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: a behavioural SHA-256 core answers each
// core_start after CORE_LATENCY cycles; a software model predicts each search
// result into a queue that a done-monitor drains and compares.
module tb_sha256_nonce_scheduler;

    localparam int CL = 65;
`ifdef DOUBLE_HASH_EN
    localparam int PER = 2 * (CL + 1) + 1;
    localparam int PASSES = 2;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
`else
    localparam int PER = CL + 2;
    localparam int PASSES = 1;
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk;
    logic         reset_n;
    logic         go, abort;
    logic [255:0] midstate, target;
    logic [95:0]  tail;
    logic [31:0]  nonce_start, nonce_end;
    logic         busy, done, found, core_start;
    logic [31:0]  nonce_out;
    logic [255:0] hash_out, core_init, core_result;
    logic [511:0] core_value;

    sha256_nonce_scheduler #(.CORE_LATENCY(CL)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .abort(abort),
        .midstate(midstate), .tail(tail), .target(target),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .busy(busy), .done(done), .found(found),
        .nonce_out(nonce_out), .hash_out(hash_out),
        .core_init(core_init), .core_value(core_value), .core_start(core_start),
        .core_result(core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain SHA-256 compression with feed-forward (what the real core returns).
    function automatic logic [255:0] sha_c(input logic [255:0] iv, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, h} = iv;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + iv[255:224], b + iv[223:192], c + iv[191:160], d + iv[159:128],
                e + iv[127:96],  f + iv[95:64],   g + iv[63:32],   h + iv[31:0]};
    endfunction

    // Software (double-)SHA256 of the 80-byte header tail with standard padding.
    function automatic logic [255:0] ref_hash(input logic [255:0] mid, input logic [95:0] tl,
                                              input logic [31:0] n);
        logic [255:0] h1;
        h1 = sha_c(mid, {tl, n, 32'h80000000, 288'h0, 64'd640});
`ifdef DOUBLE_HASH_EN
        return sha_c(IV, {h1, 32'h80000000, 160'h0, 64'd256});
`else
        return h1;
`endif
    endfunction

    // Behavioural core: correct digest only in the exact sample cycle, noise otherwise.
    logic [255:0] cm_init, cm_res;
    logic [511:0] cm_val;
    int           cm_cnt = -1;
    int           starts = 0;
    logic [31:0]  nlog [$];
    always @(negedge clk) begin
        if (!reset_n) begin
            cm_cnt = -1;
        end else if (core_start) begin
            cm_init = core_init;
            cm_val  = core_value;
            cm_res  = sha_c(core_init, core_value);
            cm_cnt  = 0;
            starts++;
            if (core_value[63:0] == 64'd640) nlog.push_back(core_value[415:384]);
        end else if (cm_cnt >= 0) begin
            cm_cnt++;
            if (cm_cnt > CL) cm_cnt = -1;
            else if (busy) begin
                total++;
                if ({core_init, core_value} !== {cm_init, cm_val}) begin
                    bad++;
                    $display("FAIL core_in_stable actual=%0h required=%0h", core_init, cm_init);
                end
            end
        end
        if (cm_cnt == CL) core_result = cm_res;
        else for (int i = 0; i < 8; i++) core_result[i*32 +: 32] = $urandom;
    end

    typedef struct {
        logic         found;
        logic [31:0]  nonce;
        logic [255:0] hash;
        int           t;
    } exp_t;
    exp_t exp_q [$];
    logic [31:0]  last_nonce = '0;
    logic [255:0] last_hash = '0;

    // Done monitor: every done pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("found", 512'(found), 512'(e.found));
                chk("nonce_out", 512'(nonce_out), 512'(e.nonce));
                chk("hash_out", 512'(hash_out), 512'(e.hash));
                chk("done_cycle", 512'(cyc), 512'(e.t));
                chk("busy_at_done", 512'(busy), 512'(0));
                last_nonce = e.nonce;
                last_hash  = e.hash;
            end
        end
    end

    // Predict the result, then pulse go for one cycle; g returns the go-sample cycle.
    task automatic run_search(input logic [255:0] mid, input logic [95:0] tl,
                              input logic [255:0] tgt, input logic [31:0] ns,
                              input logic [31:0] ne, input bit expect_done, output int g);
        exp_t e;
        logic [31:0] n;
        int tried;
        n = ns;
        tried = 0;
        e.found = 1'b0;
        for (int k = 0; k < 64; k++) begin
            e.hash = ref_hash(mid, tl, n);
            tried++;
            if (e.hash <= tgt) begin e.found = 1'b1; break; end
            if (n == ne) break;
            n = n + 32'd1;
        end
        e.nonce = n;
        @(negedge clk);
        midstate = mid; tail = tl; target = tgt; nonce_start = ns; nonce_end = ne;
        go = 1'b1;
        g = cyc;
        e.t = g + 1 + tried * PER;
        if (expect_done) exp_q.push_back(e);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=pending required=none left=%0d", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rnd256(output logic [255:0] v);
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    endtask

    initial begin
        int g, s0;
        logic [255:0] mid, tgt, ones;
        logic [95:0]  tl;
        logic [31:0]  ns;
        ones = '1;
        reset_n = 1'b0;
        go = 1'b0; abort = 1'b0;
        midstate = '0; tail = '0; target = '0; nonce_start = '0; nonce_end = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_found", 512'(found), 512'(0));
        chk("rst_core_start", 512'(core_start), 512'(0));
        chk("rst_nonce_out", 512'(nonce_out), 512'(0));
        chk("rst_hash_out", 512'(hash_out), 512'(0));
        chk("rst_core_init", 512'(core_init), 512'(0));
        chk("rst_core_value", core_value, 512'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // First-nonce hit with an all-ones target.
        rnd256(mid); tl = {$urandom, $urandom, $urandom};
        run_search(mid, tl, ones, 32'd5, 32'd9, 1'b1, g);
        wait_drain(PER + 20);

        // Full miss over three nonces.
        s0 = starts;
        rnd256(mid); tl = {$urandom, $urandom, $urandom};
        run_search(mid, tl, '0, 32'd0, 32'd2, 1'b1, g);
        wait_drain(3 * PER + 20);
        chk("start_count", 512'(starts - s0), 512'(3 * PASSES));

        // Range wrapping through zero.
        nlog.delete();
        rnd256(mid); tl = {$urandom, $urandom, $urandom};
        run_search(mid, tl, '0, 32'hFFFFFFFF, 32'd1, 1'b1, g);
        wait_drain(3 * PER + 20);
        chk("wrap_count", 512'(nlog.size()), 512'(3));
        if (nlog.size() == 3) begin
            chk("wrap_n0", 512'(nlog[0]), 512'(32'hFFFFFFFF));
            chk("wrap_n1", 512'(nlog[1]), 512'(32'h0));
            chk("wrap_n2", 512'(nlog[2]), 512'(32'h1));
        end

        // Abort at go+70: idle next cycle, no done, outputs untouched.
        rnd256(mid);
        run_search(mid, tl, '0, 32'd0, 32'd5, 1'b0, g);
        while (cyc < g + 70) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 512'(busy), 512'(0));
        repeat (3 * PER) @(negedge clk);
        chk("abort_nonce_out", 512'(nonce_out), 512'(last_nonce));
        chk("abort_hash_out", 512'(hash_out), 512'(last_hash));
        run_search(mid, tl, ones >> 1, 32'd40, 32'd42, 1'b1, g);
        wait_drain(3 * PER + 20);

        // Reset at go+100: immediate idle, no done after release.
        run_search(mid, tl, '0, 32'd7, 32'd9, 1'b0, g);
        while (cyc < g + 100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", 512'(busy), 512'(0));
        chk("mrst_core_start", 512'(core_start), 512'(0));
        chk("mrst_nonce_out", 512'(nonce_out), 512'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        last_nonce = '0; last_hash = '0;
        repeat (3 * PER) @(negedge clk);
        chk("mrst_idle", 512'(busy), 512'(0));
        chk("mrst_hash_out", 512'(hash_out), 512'(0));

        // go while busy is ignored; result follows the originally latched range.
        rnd256(mid);
        run_search(mid, tl, '0, 32'd100, 32'd102, 1'b1, g);
        while (cyc < g + 10) @(negedge clk);
        go = 1'b1; nonce_start = 32'd500; nonce_end = 32'd500; target = ones;
        @(negedge clk);
        go = 1'b0;
        wait_drain(3 * PER + 20);

        // go together with abort in IDLE is ignored.
        s0 = starts;
        @(negedge clk);
        go = 1'b1; abort = 1'b1;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        chk("goabort_busy", 512'(busy), 512'(0));
        repeat (5) @(negedge clk);
        chk("goabort_starts", 512'(starts - s0), 512'(0));

        // Randomized searches.
        for (int it = 0; it < 8; it++) begin
            int r;
            rnd256(mid); tl = {$urandom, $urandom, $urandom};
            ns = (it == 0) ? 32'hFFFFFFFE : $urandom;
            r = $urandom_range(0, 4);
            tgt = (r == 4) ? '0 : (ones >> r);
            run_search(mid, tl, tgt, ns, ns + 32'($urandom_range(0, 3)), 1'b1, g);
            wait_drain(4 * PER + 20);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
